// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port between writeback sources.
// Define REGFILE_WB_SCOREBOARD_EN to add the in-flight register scoreboard.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_dest,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rf_load,
  output logic [ADDR_W-1:0]         rf_dest,
  output logic [DATA_W-1:0]         rf_in,
  input  logic                      alloc_valid,
  input  logic [ADDR_W-1:0]         alloc_dest,
  input  logic                      flush,
  output logic [2**ADDR_W-1:0]      busy_vec
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W:0] NREQ_W = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] gnt_idx;
  logic             gnt_found;
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  // Search from rr_ptr, wrapping by compare so odd NUM_REQ works.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (sum >= NREQ_W)
        sum = sum - NREQ_W;
      idx = sum[PTR_W-1:0];
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx;
      end
    end
    if (rst)
      gnt_found = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    rf_load   = 1'b0;
    rf_dest   = '0;
    rf_in     = '0;
    if (gnt_found) begin
      req_ready[gnt_idx] = 1'b1;
      rf_load = 1'b1;
      rf_dest = req_dest[gnt_idx*ADDR_W +: ADDR_W];
      rf_in   = req_data[gnt_idx*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      rr_ptr <= '0;
    else if (gnt_found)
      rr_ptr <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
  end

`ifdef REGFILE_WB_SCOREBOARD_EN
  logic [2**ADDR_W-1:0] busy_q;
  logic [2**ADDR_W-1:0] busy_d;

  // Alloc is applied after the clear so a new producer wins.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (rf_load)
        busy_d[rf_dest] = 1'b0;
      if (alloc_valid && alloc_dest != '0)
        busy_d[alloc_dest] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

  assign busy_vec = busy_q;
`else
  logic unused_sb;
  assign unused_sb = ^{alloc_valid, alloc_dest, flush};
  assign busy_vec  = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: vector table plus
// scoreboard and three-requester sequences.
module tb_regfile_wb_arbiter;

`ifdef REGFILE_WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [9:0]  req_dest;
  logic [63:0] req_data;
  logic [1:0]  req_ready;
  logic        rf_load;
  logic [4:0]  rf_dest;
  logic [31:0] rf_in;
  logic        alloc_valid;
  logic [4:0]  alloc_dest;
  logic        flush;
  logic [31:0] busy_vec;

  logic        rst3;
  logic [2:0]  valid3;
  logic [14:0] dest3;
  logic [95:0] data3;
  logic [2:0]  ready3;
  logic        load3;
  logic [4:0]  rfd3;
  logic [31:0] rfi3;
  logic [31:0] busy3;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NUM_REQ(2), .DATA_W(32), .ADDR_W(5)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_dest(req_dest), .req_data(req_data),
    .req_ready(req_ready), .rf_load(rf_load),
    .rf_dest(rf_dest), .rf_in(rf_in),
    .alloc_valid(alloc_valid), .alloc_dest(alloc_dest),
    .flush(flush), .busy_vec(busy_vec)
  );

  regfile_wb_arbiter #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(5)) u_dut3 (
    .clk(clk), .rst(rst3),
    .req_valid(valid3), .req_dest(dest3), .req_data(data3),
    .req_ready(ready3), .rf_load(load3),
    .rf_dest(rfd3), .rf_in(rfi3),
    .alloc_valid(1'b0), .alloc_dest(5'd0),
    .flush(1'b0), .busy_vec(busy3)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  valid;
    logic [4:0]  d0, d1;
    logic [31:0] x0, x1;
    logic [1:0]  ready;
    logic        load;
    logic [4:0]  dest;
    logic [31:0] data;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] v, input logic [4:0] d0,
                         input logic [4:0] d1, input logic [31:0] x0,
                         input logic [31:0] x1);
    req_valid = v;
    req_dest  = {d1, d0};
    req_data  = {x1, x0};
  endtask

  function automatic logic [31:0] sbexp(input logic [31:0] v);
    return SB ? v : 32'h0;
  endfunction

  initial begin
    rst = 1'b1;
    req_valid = '0; req_dest = '0; req_data = '0;
    alloc_valid = 1'b0; alloc_dest = '0; flush = 1'b0;
    rst3 = 1'b1; valid3 = '0; dest3 = '0; data3 = '0;

    vt[0]  = '{1, 2'b11, 1, 2, 32'hA, 32'hB, 2'b00, 0, 0, 0};
    vt[1]  = '{0, 2'b11, 1, 2, 32'hA, 32'hB, 2'b01, 1, 1, 32'hA};
    vt[2]  = '{0, 2'b11, 1, 2, 32'hA, 32'hB, 2'b10, 1, 2, 32'hB};
    vt[3]  = '{0, 2'b11, 3, 4, 32'hC, 32'hD, 2'b01, 1, 3, 32'hC};
    vt[4]  = '{0, 2'b11, 3, 4, 32'hC, 32'hD, 2'b10, 1, 4, 32'hD};
    vt[5]  = '{0, 2'b10, 1, 5, 32'h1, 32'hDEADBEEF,
               2'b10, 1, 5, 32'hDEADBEEF};
    vt[6]  = '{0, 2'b11, 6, 7, 32'h66, 32'h77, 2'b01, 1, 6, 32'h66};
    vt[7]  = '{0, 2'b00, 6, 7, 32'h66, 32'h77, 2'b00, 0, 0, 0};
    vt[8]  = '{0, 2'b01, 8, 9, 32'h88, 32'h99, 2'b01, 1, 8, 32'h88};
    vt[9]  = '{0, 2'b11, 8, 9, 32'h88, 32'h99, 2'b10, 1, 9, 32'h99};
    vt[10] = '{0, 2'b01, 0, 9, 32'h123, 32'h99, 2'b01, 1, 0, 32'h123};
    vt[11] = '{1, 2'b11, 1, 2, 32'hA, 32'hB, 2'b00, 0, 0, 0};
    vt[12] = '{0, 2'b11, 1, 2, 32'hA, 32'hB, 2'b01, 1, 1, 32'hA};

    tick();
    for (int i = 0; i < 13; i++) begin
      rst = vt[i].rst;
      set_req(vt[i].valid, vt[i].d0, vt[i].d1, vt[i].x0, vt[i].x1);
      #3;
      chk($sformatf("v%0d.ready", i), 64'(req_ready), 64'(vt[i].ready));
      chk($sformatf("v%0d.load", i), 64'(rf_load), 64'(vt[i].load));
      chk($sformatf("v%0d.dest", i), 64'(rf_dest), 64'(vt[i].dest));
      chk($sformatf("v%0d.data", i), 64'(rf_in), 64'(vt[i].data));
      chk($sformatf("v%0d.busy", i), 64'(busy_vec), 64'(0));
      tick();
    end

    rst = 1'b1; set_req(2'b00, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    chk("post_rst_ready", 64'(req_ready), 64'(0));
    chk("post_rst_dest", 64'(rf_dest), 64'(0));
    chk("post_rst_busy", 64'(busy_vec), 64'(0));

    alloc_valid = 1'b1; alloc_dest = 5'd7;
    tick();
    chk("sb_alloc7", 64'(busy_vec), 64'(sbexp(32'h80)));
    set_req(2'b01, 7, 0, 32'h70, 0);
    #3;
    chk("sb_wr7_ready", 64'(req_ready), 64'(2'b01));
    tick();
    chk("sb_set_wins", 64'(busy_vec), 64'(sbexp(32'h80)));
    alloc_valid = 1'b0;
    set_req(2'b10, 0, 7, 0, 32'h71);
    tick();
    chk("sb_clear7", 64'(busy_vec), 64'(0));
    set_req(2'b00, 0, 0, 0, 0);
    alloc_valid = 1'b1; alloc_dest = 5'd0;
    tick();
    chk("sb_alloc0", 64'(busy_vec), 64'(0));
    alloc_dest = 5'd3;
    tick();
    alloc_dest = 5'd9;
    tick();
    chk("sb_3_9", 64'(busy_vec), 64'(sbexp(32'h208)));
    alloc_valid = 1'b0; flush = 1'b1;
    tick();
    chk("sb_flush", 64'(busy_vec), 64'(0));
    alloc_valid = 1'b1; alloc_dest = 5'd12;
    tick();
    chk("sb_flush_wins", 64'(busy_vec), 64'(0));
    flush = 1'b0; alloc_valid = 1'b0;

    rst3 = 1'b0;
    valid3 = 3'b111;
    dest3 = {5'd12, 5'd11, 5'd10};
    data3 = {32'h2222, 32'h1111, 32'h0000};
    for (int i = 0; i < 8; i++) begin
      #3;
      chk($sformatf("n3_g%0d", i), 64'(ready3), 64'(3'b001 << (i % 3)));
      chk($sformatf("n3_d%0d", i), 64'(rfd3), 64'(10 + (i % 3)));
      tick();
    end
    rst3 = 1'b1;
    #3;
    chk("n3_rst_ready", 64'(ready3), 64'(0));
    chk("n3_rst_load", 64'(load3), 64'(0));
    tick();
    rst3 = 1'b0;
    #3;
    chk("n3_restart", 64'(ready3), 64'(3'b001));
    chk("n3_busy", 64'(busy3), 64'(0));
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
